// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU:
//   - default operand width and opcode-vector width
//   - opcode index constants (the bit position of each op in ctrl_signal)
//   - control FSM state encoding
// Optional feature macro used by the design: SEQ_ALU_DIV_EN (compiles in the
// iterative divider; without it a div opcode is reported as illegal).
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_BITS_DEFAULT      = 32;
    localparam int ALU_SIG_COUNT_DEFAULT = 12;
    localparam int NUM_OPS               = 12;

    // Each value is the bit index of that opcode inside the one-hot vector.
    // OP_ILL is an internal code for anything that must complete with err=1.
    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_SHR = 4'd4,
        OP_SHL = 4'd5,
        OP_ROR = 4'd6,
        OP_ROL = 4'd7,
        OP_AND = 4'd8,
        OP_OR  = 4'd9,
        OP_NEG = 4'd10,
        OP_NOT = 4'd11,
        OP_ILL = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // Ops that are handed to the iterative multiply/divide engine.
    function automatic logic is_iter_op(input op_e op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// -----------------------------------------------------------------------------
// alu_muldiv_iter
// Iterative signed multiply (shift-add) and, when SEQ_ALU_DIV_EN is defined,
// signed restoring divide. Both run on operand magnitudes for BITS steps and
// apply the sign correction combinationally on the way out.
//
// Ports:
//   clk, clr_n   clock, asynchronous active-low reset (aborts an operation)
//   start_i      one-cycle load strobe; operands sampled on the same edge
//   div_i        1 = divide, 0 = multiply (present only with SEQ_ALU_DIV_EN)
//   a_i, b_i     signed operands (multiplicand/dividend, multiplier/divisor)
//   done_o       high for exactly one cycle, BITS cycles after the load edge
//   result_o     product, or {remainder, quotient}; valid while done_o is high
//
// Timing: load on edge E0, iterations on E1..E_BITS, done_o high in the cycle
// after E_BITS so the parent can register result_o on edge E_BITS+1.
// -----------------------------------------------------------------------------
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int BITS = ALU_BITS_DEFAULT
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start_i,
`ifdef SEQ_ALU_DIV_EN
    input  logic              div_i,
`endif
    input  logic [BITS-1:0]   a_i,
    input  logic [BITS-1:0]   b_i,
    output logic              done_o,
    output logic [2*BITS-1:0] result_o
);

    localparam int CW = $clog2(BITS) + 1;

    logic            running_q, running_d;
    logic [CW-1:0]   count_q, count_d;
    logic [BITS-1:0] acc_q, acc_d;      // high product half / partial remainder
    logic [BITS-1:0] lo_q, lo_d;        // multiplier bits / dividend -> quotient
    logic [BITS-1:0] mcand_q, mcand_d;  // |multiplicand| or |divisor|
    logic            neg_q, neg_d;      // product or quotient must be negated

    logic [BITS:0]     mul_sum;
    logic [2*BITS-1:0] prod;

`ifdef SEQ_ALU_DIV_EN
    logic            div_q, div_d;
    logic            rem_neg_q, rem_neg_d;
    logic [BITS:0]   div_shift, div_trial;
    logic [BITS-1:0] quo_fix, rem_fix;
`endif

    function automatic logic [BITS-1:0] mag(input logic [BITS-1:0] v);
        // The most-negative value maps to 2^(BITS-1), still representable
        // as an unsigned BITS-bit magnitude.
        return v[BITS-1] ? (BITS'(0) - v) : v;
    endfunction

    // NOTE: every variable assigned in this block receives a default before
    // any branch, so no path leaves a value unassigned and no latch appears.
    always_comb begin
        running_d = running_q;
        count_d   = count_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        mcand_d   = mcand_q;
        neg_d     = neg_q;
`ifdef SEQ_ALU_DIV_EN
        div_d     = div_q;
        rem_neg_d = rem_neg_q;
        div_shift = {acc_q, lo_q[BITS-1]};
        div_trial = div_shift - {1'b0, mcand_q};
`endif
        // Add the multiplicand when the current multiplier bit is set; the
        // carry lands in the top bit and is shifted down with everything else.
        mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);

        if (start_i) begin
            running_d = 1'b1;
            count_d   = '0;
            acc_d     = '0;
            lo_d      = mag(a_i);
            mcand_d   = mag(b_i);
            neg_d     = a_i[BITS-1] ^ b_i[BITS-1];
`ifdef SEQ_ALU_DIV_EN
            div_d     = div_i;
            rem_neg_d = a_i[BITS-1];
`endif
        end else if (running_q) begin
            if (count_q == CW'(BITS)) begin
                running_d = 1'b0;
            end else begin
                count_d = count_q + CW'(1);
`ifdef SEQ_ALU_DIV_EN
                if (div_q) begin
                    // Restoring step: keep the trial difference only when it
                    // did not go negative.
                    if (!div_trial[BITS]) begin
                        acc_d = div_trial[BITS-1:0];
                        lo_d  = {lo_q[BITS-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift[BITS-1:0];
                        lo_d  = {lo_q[BITS-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum[BITS:1];
                    lo_d  = {mul_sum[0], lo_q[BITS-1:1]};
                end
`else
                acc_d = mul_sum[BITS:1];
                lo_d  = {mul_sum[0], lo_q[BITS-1:1]};
`endif
            end
        end
    end

    always_comb begin
        prod     = {acc_q, lo_q};
        result_o = neg_q ? ('0 - prod) : prod;
`ifdef SEQ_ALU_DIV_EN
        // Truncating division: quotient sign is the XOR of the operand signs,
        // remainder takes the sign of the dividend.
        quo_fix = neg_q     ? (BITS'(0) - lo_q)  : lo_q;
        rem_fix = rem_neg_q ? (BITS'(0) - acc_q) : acc_q;
        if (div_q) begin
            result_o = {rem_fix, quo_fix};
        end
`endif
    end

    assign done_o = running_q && (count_q == CW'(BITS));

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            running_q <= 1'b0;
            count_q   <= '0;
        end else begin
            running_q <= running_d;
            count_q   <= count_d;
        end
    end

    // NOTE: the datapath registers are deliberately left without reset; they
    // are always loaded on start_i before being observed, and only the control
    // flops above need a defined value after clr_n.
    always_ff @(posedge clk) begin
        acc_q     <= acc_d;
        lo_q      <= lo_d;
        mcand_q   <= mcand_d;
        neg_q     <= neg_d;
`ifdef SEQ_ALU_DIV_EN
        div_q     <= div_d;
        rem_neg_q <= rem_neg_d;
`endif
    end

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Sequential ALU with a one-hot opcode input. Single-cycle ops finish one
// cycle after the accepting edge; mul/div run on alu_muldiv_iter and finish
// BITS+1 cycles after it. Control FSM: IDLE -> EXEC -> FIN -> IDLE.
//
// Ports:
//   clk          rising-edge clock
//   clr_n        asynchronous active-low reset, aborts any operation
//   start        request strobe, sampled only in IDLE
//   ctrl_signal  one-hot opcode (bit 0 add ... bit 11 not, see alu_pkg)
//   X, Y         operands, captured on the accepting edge
//   busy         high while an operation is executing (EXEC state)
//   done         one-cycle completion pulse (FIN state)
//   err          high with done for an illegal opcode or divide-by-zero
//   result       2*BITS result, held until the next completion
//
// Build option: define SEQ_ALU_DIV_EN to include the divider; otherwise the
// div opcode completes immediately with err=1.
// -----------------------------------------------------------------------------
module seq_alu
    import alu_pkg::*;
#(
    parameter int BITS      = ALU_BITS_DEFAULT,
    parameter int SIG_COUNT = ALU_SIG_COUNT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 start,
    input  logic [SIG_COUNT-1:0] ctrl_signal,
    input  logic [BITS-1:0]      X,
    input  logic [BITS-1:0]      Y,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [2*BITS-1:0]    result
);

    localparam int                   SH      = $clog2(BITS);
    localparam logic [SIG_COUNT-1:0] SIG_ONE = SIG_COUNT'(1);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [BITS-1:0]   x_q, x_d;
    logic [BITS-1:0]   y_q, y_d;
    logic [2*BITS-1:0] result_q, result_d;
    logic              err_q, err_d;

    op_e               dec_op;
    logic              accept;
    logic              iter_start;
    logic              iter_done;
    logic [2*BITS-1:0] iter_result;

    logic [BITS-1:0]   sum, diff;
    logic [SH-1:0]     amt;
    logic [2*BITS-1:0] alu_res;

    // Opcode decode: exactly one bit among the known positions must be set;
    // zero bits, several bits, or an unknown position all decode to OP_ILL.
    always_comb begin
        dec_op = OP_ILL;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (i < SIG_COUNT && ctrl_signal == (SIG_ONE << i)) begin
                dec_op = op_e'(4'(i));
            end
        end
`ifdef SEQ_ALU_DIV_EN
        // Divide-by-zero is reported exactly like an illegal opcode.
        if (dec_op == OP_DIV && Y == '0) begin
            dec_op = OP_ILL;
        end
`else
        if (dec_op == OP_DIV) begin
            dec_op = OP_ILL;
        end
`endif
    end

    assign accept     = (state_q == ST_IDLE) && start;
    assign iter_start = accept && is_iter_op(dec_op);

    // The iterative engine is fed straight from the ports on the accepting
    // edge so its BITS steps line up with the EXEC window.
    alu_muldiv_iter #(
        .BITS (BITS)
    ) u_muldiv (
        .clk      (clk),
        .clr_n    (clr_n),
        .start_i  (iter_start),
`ifdef SEQ_ALU_DIV_EN
        .div_i    (dec_op == OP_DIV),
`endif
        .a_i      (X),
        .b_i      (Y),
        .done_o   (iter_done),
        .result_o (iter_result)
    );

    // Single-cycle datapath, evaluated from the captured operands during EXEC.
    always_comb begin
        sum     = x_q + y_q;
        diff    = x_q - y_q;
        amt     = y_q[SH-1:0];
        alu_res = '0;
        case (op_q)
            OP_ADD: alu_res = {{BITS{sum[BITS-1]}}, sum};
            OP_SUB: alu_res = {{BITS{diff[BITS-1]}}, diff};
            OP_SHR: alu_res = {{BITS{1'b0}}, x_q >> amt};
            OP_SHL: alu_res = {{BITS{1'b0}}, x_q << amt};
            // For amt == 0 the complementary shift is by BITS, which yields 0.
            OP_ROR: alu_res = {{BITS{1'b0}}, (x_q >> amt) | (x_q << (BITS - int'(amt)))};
            OP_ROL: alu_res = {{BITS{1'b0}}, (x_q << amt) | (x_q >> (BITS - int'(amt)))};
            OP_AND: alu_res = {{BITS{1'b0}}, x_q & y_q};
            OP_OR:  alu_res = {{BITS{1'b0}}, x_q | y_q};
            OP_NEG: alu_res = {{BITS{1'b0}}, BITS'(0) - x_q};
            OP_NOT: alu_res = {{BITS{1'b0}}, ~x_q};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        x_d      = x_q;
        y_d      = y_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_EXEC;
                    op_d    = dec_op;
                    x_d     = X;
                    y_d     = Y;
                end
            end
            ST_EXEC: begin
                if (is_iter_op(op_q)) begin
                    if (iter_done) begin
                        state_d  = ST_FIN;
                        result_d = iter_result;
                        err_d    = 1'b0;
                    end
                end else begin
                    state_d  = ST_FIN;
                    err_d    = (op_q == OP_ILL);
                    result_d = (op_q == OP_ILL) ? '0 : alu_res;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q <= op_d;
        x_q  <= x_d;
        y_q  <= y_d;
    end

    assign busy   = (state_q == ST_EXEC);
    assign done   = (state_q == ST_FIN);
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
// Directed scoreboard bench for seq_alu (BITS=32, SIG_COUNT=12). The stimulus
// process pushes the expected result, err, completion cycle and busy length
// when a request is accepted; the monitor pops and compares on every done.
// Expectations for the div opcode follow the SEQ_ALU_DIV_EN build setting.
// -----------------------------------------------------------------------------
module tb_seq_alu;

    localparam int W    = 32;
    localparam int MLAT = W + 1;

    localparam logic [11:0] C_ADD = 12'h001;
    localparam logic [11:0] C_SUB = 12'h002;
    localparam logic [11:0] C_MUL = 12'h004;
    localparam logic [11:0] C_DIV = 12'h008;
    localparam logic [11:0] C_SHR = 12'h010;
    localparam logic [11:0] C_SHL = 12'h020;
    localparam logic [11:0] C_ROR = 12'h040;
    localparam logic [11:0] C_ROL = 12'h080;
    localparam logic [11:0] C_AND = 12'h100;
    localparam logic [11:0] C_OR  = 12'h200;
    localparam logic [11:0] C_NEG = 12'h400;
    localparam logic [11:0] C_NOT = 12'h800;

    logic          clk = 1'b0;
    logic          clr_n = 1'b0;
    logic          start = 1'b0;
    logic [11:0]   ctrl_signal = '0;
    logic [W-1:0]  X = '0;
    logic [W-1:0]  Y = '0;
    logic          busy, done, err;
    logic [2*W-1:0] result;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int busy_cnt = 0;

    typedef struct {
        string       name;
        logic [63:0] res;
        logic        err;
        int          due;
        int          busy;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_alu #(
        .BITS      (W),
        .SIG_COUNT (12)
    ) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .start       (start),
        .ctrl_signal (ctrl_signal),
        .X           (X),
        .Y           (Y),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .result      (result)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every completion against the oldest expectation.
    always @(negedge clk) begin
        if (!clr_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (!done) check("err_outside_done", {63'd0, err}, 64'd0);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.name, ".result"}, result, mon_e.res);
                    check({mon_e.name, ".err"}, {63'd0, err}, {63'd0, mon_e.err});
                    check({mon_e.name, ".done_cycle"}, 64'(cyc), 64'(mon_e.due));
                    check({mon_e.name, ".busy_cycles"}, 64'(busy_cnt), 64'(mon_e.busy));
                    check({mon_e.name, ".busy_at_done"}, {63'd0, busy}, 64'd0);
                end
                busy_cnt = 0;
            end
        end
    end

    // Drive a request (caller sits on a negedge), push the expectation on the
    // accepting edge, then scramble inputs to show they are not re-sampled.
    task automatic issue(input string name, input logic [11:0] c, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [63:0] r, input logic e,
                         input int lat);
        exp_t t;
        start       = 1'b1;
        ctrl_signal = c;
        X           = x;
        Y           = y;
        @(posedge clk);
        #1;
        t.name = name;
        t.res  = r;
        t.err  = e;
        t.due  = cyc + lat;
        t.busy = lat;
        sb.push_back(t);
        start       = 1'b0;
        X           = $urandom;
        Y           = $urandom;
        ctrl_signal = 12'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy && !done) return;
        end
        check("wait_idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0) return;
        end
        check("wait_done_timeout", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic run(input string name, input logic [11:0] c, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [63:0] r, input logic e,
                       input int lat);
        wait_idle();
        issue(name, c, x, y, r, e, lat);
        wait_done();
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst.busy",   {63'd0, busy}, 64'd0);
        check("rst.done",   {63'd0, done}, 64'd0);
        check("rst.err",    {63'd0, err},  64'd0);
        check("rst.result", result,        64'd0);

        // Release reset and request in the same cycle: the very next edge accepts.
        clr_n = 1'b1;
        issue("add_ovf", C_ADD, 32'h7FFF_FFFF, 32'h1, 64'hFFFF_FFFF_8000_0000, 1'b0, 1);
        wait_done();
        repeat (3) @(negedge clk);
        check("add_ovf.held", result, 64'hFFFF_FFFF_8000_0000);

        run("add_wrap", C_ADD, 32'hFFFF_FFFF, 32'h1,         64'h0,                   1'b0, 1);
        run("sub_neg",  C_SUB, 32'd5,         32'd7,         64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1);

        // mul with a stray start in the middle of the operation
        wait_idle();
        issue("mul_m3x7", C_MUL, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, MLAT);
        repeat (5) @(negedge clk);
        start = 1'b1; ctrl_signal = C_ADD; X = 32'd1; Y = 32'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        run("mul_max_min", C_MUL, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 1'b0, MLAT);
        run("mul_min_min", C_MUL, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, MLAT);
        run("mul_zero",    C_MUL, 32'd0,         32'hFFFF_FFFB, 64'h0,                   1'b0, MLAT);

`ifdef SEQ_ALU_DIV_EN
        run("div_m7_2", C_DIV, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 1'b0, MLAT);
        run("div_7_m2", C_DIV, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0, MLAT);
`else
        run("div_off",  C_DIV, 32'hFFFF_FFF9, 32'd2,         64'h0,                   1'b1, 1);
`endif
        run("div_by0",  C_DIV, 32'd7,         32'd0,         64'h0,                   1'b1, 1);

        run("ror_1_4",  C_ROR, 32'h0000_0001, 32'd4,         64'h0000_0000_1000_0000, 1'b0, 1);
        run("rol_1",    C_ROL, 32'h8000_0001, 32'd1,         64'h0000_0000_0000_0003, 1'b0, 1);
        run("ror_0",    C_ROR, 32'h1234_5678, 32'h20,        64'h0000_0000_1234_5678, 1'b0, 1);
        run("shr_31",   C_SHR, 32'h8000_0000, 32'd31,        64'h0000_0000_0000_0001, 1'b0, 1);
        run("shr_amt",  C_SHR, 32'hF000_0000, 32'h24,        64'h0000_0000_0F00_0000, 1'b0, 1);
        run("shl_31",   C_SHL, 32'h0000_0001, 32'd31,        64'h0000_0000_8000_0000, 1'b0, 1);
        run("and",      C_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 64'h0000_0000_0F00_0F00, 1'b0, 1);
        run("or",       C_OR,  32'hFF00_FF00, 32'h0F0F_0F0F, 64'h0000_0000_FF0F_FF0F, 1'b0, 1);
        run("neg_5",    C_NEG, 32'd5,         32'd0,         64'h0000_0000_FFFF_FFFB, 1'b0, 1);
        run("neg_min",  C_NEG, 32'h8000_0000, 32'd0,         64'h0000_0000_8000_0000, 1'b0, 1);
        run("ill_two",  12'h003, 32'd1,       32'd1,         64'h0,                   1'b1, 1);
        run("ill_none", 12'h000, 32'd1,       32'd1,         64'h0,                   1'b1, 1);
        run("not",      C_NOT, 32'h1234_5678, 32'd0,         64'h0000_0000_EDCB_A987, 1'b0, 1);

        // Abort a multiply with reset partway through
        wait_idle();
        issue("mul_abort", C_MUL, 32'd9, 32'd9, 64'd81, 1'b0, MLAT);
        repeat (10) @(negedge clk);
        clr_n = 1'b0;
        #1;
        check("abort.busy",   {63'd0, busy}, 64'd0);
        check("abort.done",   {63'd0, done}, 64'd0);
        check("abort.err",    {63'd0, err},  64'd0);
        check("abort.result", result,        64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        issue("add_after_rst", C_ADD, 32'd2, 32'd3, 64'd5, 1'b0, 1);
        wait_done();

        // Quiet window: a late done from the aborted multiply would be flagged.
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
